// File: rtl/pc_fetch_sequencer.sv
// PC / instruction-fetch sequencer: holds the PC at the reset vector while cleared,
// fetches from instruction memory with req/ack and hands words to decode via valid/ready.
module pc_fetch_sequencer #(
  parameter int unsigned           ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr_pc,
  input  logic                  enable_pd,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_ack,
  input  logic [ADDR_WIDTH-1:0] imem_rdata,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [ADDR_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  input  logic                  branch_taken,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  misalign,
  output logic [1:0]            dbg_state_o
);

  typedef enum logic [1:0] {
    HALT    = 2'd0,
    REQ     = 2'd1,
    DELIVER = 2'd2
  } state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic                  imem_req_q;
  logic                  instr_valid_q;
  logic                  misalign_q;
  logic [ADDR_WIDTH-1:0] instr_q;
  logic [ADDR_WIDTH-1:0] instr_pc_q;
  logic [ADDR_WIDTH-1:0] pc_d;

  // Handshakes: a memory word is taken on any cycle with imem_req & imem_ack;
  // decode takes the word on any cycle with instr_valid & instr_ready, and
  // instr/instr_pc are held stable from valid rising until that accept.
  always_comb begin
    pc_d = pc_q + ADDR_WIDTH'(4);
    if (branch_taken) begin
      pc_d = {branch_target[ADDR_WIDTH-1:2], 2'b00};
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clr_pc) begin
      state_q       <= HALT;
      pc_q          <= RESET_VECTOR;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
      misalign_q    <= 1'b0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
    end else begin
      misalign_q <= 1'b0;
      unique case (state_q)
        HALT: begin
          if (enable_pd) begin
            state_q    <= REQ;
            imem_req_q <= 1'b1;
          end
        end
        REQ: begin
          if (imem_ack) begin
            instr_q       <= imem_rdata;
            instr_pc_q    <= pc_q;
            instr_valid_q <= 1'b1;
            imem_req_q    <= 1'b0;
            state_q       <= DELIVER;
          end
        end
        DELIVER: begin
          if (instr_ready) begin
            instr_valid_q <= 1'b0;
            pc_q          <= pc_d;
            misalign_q    <= branch_taken & (branch_target[1:0] != 2'b00);
            // A fetch already issued is always delivered; enable only gates the next one.
            if (enable_pd) begin
              state_q    <= REQ;
              imem_req_q <= 1'b1;
            end else begin
              state_q <= HALT;
            end
          end
        end
        default: begin
          state_q       <= HALT;
          imem_req_q    <= 1'b0;
          instr_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = pc_q;
  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign pc          = pc_q;
  assign misalign    = misalign_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench for pc_fetch_sequencer: memory responses push expected {pc, word}
// into a queue, decode accepts pop and compare.
module tb_pc_fetch_sequencer;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         clr_pc;
  logic         enable_pd;
  logic         imem_req;
  logic [W-1:0] imem_addr;
  logic         imem_ack;
  logic [W-1:0] imem_rdata;
  logic         instr_valid;
  logic         instr_ready;
  logic [W-1:0] instr;
  logic [W-1:0] instr_pc;
  logic         branch_taken;
  logic [W-1:0] branch_target;
  logic [W-1:0] pc;
  logic         misalign;
  logic [1:0]   dbg_state_o;

  logic [2*W-1:0] exp_q[$];
  logic [W-1:0]   mpc;
  int             n_checks = 0;
  int             n_fail   = 0;

  localparam logic [1:0] S_HALT = 2'd0, S_REQ = 2'd1, S_DELIVER = 2'd2;

  pc_fetch_sequencer #(.ADDR_WIDTH(W), .RESET_VECTOR(32'h0)) dut (
    .clk(clk), .reset(reset), .clr_pc(clr_pc), .enable_pd(enable_pd),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc), .branch_taken(branch_taken),
    .branch_target(branch_target), .pc(pc), .misalign(misalign),
    .dbg_state_o(dbg_state_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_req"}, {31'b0, imem_req}, 32'd0);
    chk({tag, "_valid"}, {31'b0, instr_valid}, 32'd0);
    chk({tag, "_pc"}, pc, mpc);
    chk({tag, "_state"}, {30'b0, dbg_state_o}, {30'b0, S_HALT});
  endtask

  // Entered with the DUT in REQ. Branch noise is driven during REQ and stall cycles.
  task automatic do_fetch(input int waits, input int stalls, input logic bt,
                          input logic [W-1:0] btgt, input logic en_after);
    logic [2*W-1:0] e;
    enable_pd = en_after;
    chk("req_hi", {31'b0, imem_req}, 32'd1);
    chk("req_addr", imem_addr, mpc);
    branch_taken  = 1'b1;
    branch_target = 32'h0000_0102;
    for (int i = 0; i < waits; i++) begin
      imem_ack = 1'b0;
      tick();
      chk("wait_req", {31'b0, imem_req}, 32'd1);
      chk("wait_addr", imem_addr, mpc);
      chk("wait_valid", {31'b0, instr_valid}, 32'd0);
    end
    imem_ack   = 1'b1;
    imem_rdata = 32'hA0 + mpc;
    exp_q.push_back({mpc, 32'hA0 + mpc});
    tick();
    imem_ack   = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    chk("ack_valid", {31'b0, instr_valid}, 32'd1);
    chk("ack_req", {31'b0, imem_req}, 32'd0);
    chk("misalign_idle", {31'b0, misalign}, 32'd0);
    e = exp_q[0];
    for (int i = 0; i < stalls; i++) begin
      instr_ready = 1'b0;
      tick();
      chk("stall_valid", {31'b0, instr_valid}, 32'd1);
      chk("stall_instr", instr, e[W-1:0]);
      chk("stall_instr_pc", instr_pc, e[2*W-1:W]);
    end
    e = exp_q.pop_front();
    chk("acc_instr", instr, e[W-1:0]);
    chk("acc_instr_pc", instr_pc, e[2*W-1:W]);
    instr_ready   = 1'b1;
    branch_taken  = bt;
    branch_target = btgt;
    tick();
    instr_ready  = 1'b0;
    branch_taken = 1'b0;
    mpc = bt ? {btgt[W-1:2], 2'b00} : mpc + 32'd4;
    chk("post_valid", {31'b0, instr_valid}, 32'd0);
    chk("post_pc", pc, mpc);
    chk("post_req", {31'b0, imem_req}, {31'b0, en_after});
    chk("post_misalign", {31'b0, misalign}, {31'b0, bt & (btgt[1:0] != 2'b00)});
  endtask

  initial begin
    reset = 1'b1; clr_pc = 1'b0; enable_pd = 1'b0; imem_ack = 1'b0;
    imem_rdata = '0; instr_ready = 1'b0; branch_taken = 1'b0; branch_target = '0;
    mpc = 32'h0;
    tick(); tick();
    chk_idle("reset");
    chk("reset_instr", instr, 32'd0);
    chk("reset_instr_pc", instr_pc, 32'd0);
    chk("reset_misalign", {31'b0, misalign}, 32'd0);
    reset = 1'b0; clr_pc = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_idle("clr_hold");
    end
    enable_pd = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_idle("clr_beats_en");
    end
    clr_pc = 1'b0;
    tick();
    chk("start_state", {30'b0, dbg_state_o}, {30'b0, S_REQ});

    for (int i = 0; i < 4; i++) do_fetch(0, 0, 1'b0, '0, 1'b1);
    do_fetch(3, 2, 1'b1, 32'h0000_0008, 1'b1);
    do_fetch(0, 0, 1'b1, 32'h0000_0102, 1'b1);
    chk("branch_addr", imem_addr, 32'h0000_0100);
    tick();
    chk("misalign_pulse_end", {31'b0, misalign}, 32'd0);
    do_fetch(0, 1, 1'b1, 32'hFFFF_FFFC, 1'b1);
    do_fetch(1, 0, 1'b0, '0, 1'b1);
    chk("wrap_addr", imem_addr, 32'h0);
    do_fetch(2, 0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_idle("halt_after_drop");
    end

    enable_pd = 1'b1;
    tick();
    chk("reenable_req", {31'b0, imem_req}, 32'd1);
    chk("reenable_addr", imem_addr, mpc);
    imem_ack = 1'b1; imem_rdata = 32'h1234_5678; clr_pc = 1'b1;
    tick();
    imem_ack = 1'b0; clr_pc = 1'b0; enable_pd = 1'b0;
    mpc = 32'h0;
    chk_idle("clr_mid_req");
    chk("clr_mid_instr", instr, 32'd0);
    tick();
    chk_idle("clr_then_halt");
    tick();
    chk_idle("clr_then_halt2");
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
